// File: rtl/core_pkg.sv
// Shared core definitions: default reset PC, fetch buffer entry layout and
// the word-alignment helper used when loading redirect targets.
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
//   imem_req/imem_addr : request valid and word-aligned address (fetch side)
//   imem_ack           : request accepted this cycle (memory side)
//   imem_rvalid/rdata  : in-order read response (memory side)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/instr_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO of {pc, ir} entries.
//   clk, reset : clock and synchronous active-high reset
//   clear      : drop all entries (takes priority over push/pop)
//   push, din  : write an entry at the tail
//   pop        : retire the head entry
//   dout       : head entry (combinational)
//   count      : number of valid entries
module instr_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               din,
  input  logic                       pop,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches under a credit limit,
// buffers responses, and redirects on EX flush or predicted-taken jumps.
//   clk, reset          : clock, synchronous active-high reset
//   imem                : instruction memory bus (master side)
//   valid_out/ready_out : head-of-buffer handshake toward decode
//   PC_IF/IR_IF         : PC and instruction of the head entry
//   jump_pred_IF/addr   : predictor verdict and target for the head
//   flush_EX/target_EX  : EX-stage redirect and target
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [31:0]         PC_IF,
  output logic [31:0]         IR_IF,
  input  logic                jump_pred_IF,
  input  logic [31:0]         jump_addr_IF,
  input  logic                flush_EX,
  input  logic [31:0]         target_EX
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic          pop;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          credit_ok;
  logic          fire;
  logic          rsp;
  logic          push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign valid_out   = (count != '0);
  assign pop         = valid_out && ready_out;
  assign redirect    = flush_EX || (pop && jump_pred_IF);
  assign redirect_pc = word_align(flush_EX ? target_EX : jump_addr_IF);

  // Buffered plus in-flight entries may never exceed DEPTH, so every
  // response is guaranteed a free slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);

  assign imem.imem_req  = !reset && !redirect && credit_ok;
  assign imem.imem_addr = fetch_pc;

  assign fire = imem.imem_req && imem.imem_ack;
  assign rsp  = imem.imem_rvalid && !reset;
  // Responses still owed from before a redirect are counted in drop and
  // discarded; a response landing in the redirect cycle is discarded too.
  assign push = rsp && (drop == '0) && !redirect;

  assign push_entry = '{pc: rsp_pc, ir: imem.imem_rdata};
  assign PC_IF      = head.pc;
  assign IR_IF      = head.ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outstanding - CW'(rsp);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp) begin
          if (drop != '0) drop   <= drop - 1'b1;
          else            rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) !(imem.imem_rvalid && outstanding == '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stalls/redirects,
// checked against a stream-level reference model (expected delivered PC,
// expected next fetch address, in-flight request queue as memory model).
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] PC_IF;
  logic [31:0] IR_IF;
  logic        jump_pred_IF;
  logic [31:0] jump_addr_IF;
  logic        flush_EX;
  logic [31:0] target_EX;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .PC_IF        (PC_IF),
    .IR_IF        (IR_IF),
    .jump_pred_IF (jump_pred_IF),
    .jump_addr_IF (jump_addr_IF),
    .flush_EX     (flush_EX),
    .target_EX    (target_EX)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] pending[$];
  logic [31:0] fired_q[$];
  int          deliveries = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample and update
  // the reference model just before the rising edge that acts on them.
  task automatic step(input logic rst, input logic ack, input logic rv, input logic rdy,
                      input logic pred, input logic [31:0] ja, input logic fl,
                      input logic [31:0] tg);
    @(negedge clk);
    reset            = rst;
    imem.imem_ack    = ack;
    imem.imem_rvalid = rv && !rst && (pending.size() > 0);
    imem.imem_rdata  = imem.imem_rvalid ? ir_of(pending[0]) : $urandom;
    ready_out        = rdy;
    jump_pred_IF     = pred;
    jump_addr_IF     = ja;
    flush_EX         = fl;
    target_EX        = tg;
    #1;
    s_req   = imem.imem_req;
    s_addr  = imem.imem_addr;
    s_valid = valid_out;
    s_pc    = PC_IF;
    if (rst) begin
      pending.delete();
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
    end else begin
      if (fl || (valid_out && rdy && pred))
        check_eq("req_on_redirect", {31'b0, imem.imem_req}, 32'd0);
      if (imem.imem_req && ack) begin
        check_eq("fetch_addr", imem.imem_addr, exp_fetch);
        pending.push_back(imem.imem_addr);
        fired_q.push_back(imem.imem_addr);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (valid_out && rdy && !fl) begin
        check_eq("deliver_pc", PC_IF, exp_pc);
        check_eq("deliver_ir", IR_IF, ir_of(exp_pc));
        deliveries++;
        if (pred) begin
          exp_pc    = align4(ja);
          exp_fetch = exp_pc;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (fl) begin
        exp_pc    = align4(tg);
        exp_fetch = exp_pc;
      end
      if (imem.imem_rvalid) void'(pending.pop_front());
      check_eq("credit", {31'b0, pending.size() <= DEPTH}, 32'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pending.size() > 0; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("drain", pending.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_del;
    int d0;
    int got_fires;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("reset_valid", {31'b0, s_valid}, 32'd0);
    check_eq("reset_req", {31'b0, s_req}, 32'd0);

    // Streaming from reset: first request at address 0, PC 0 two cycles later
    fired_q.delete();
    first_del = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      if (i == 0) begin
        check_eq("first_req", {31'b0, s_req}, 32'd1);
        check_eq("first_addr", s_addr, 32'h0);
      end
      if (s_valid && first_del < 0) begin
        first_del = i;
        check_eq("first_pc", s_pc, 32'h0);
      end
    end
    check_eq("first_latency", first_del, 32'd2);
    check_eq("stream_addr1", fired_q[1], 32'h4);
    check_eq("stream_addr2", fired_q[2], 32'h8);

    // Backpressure: exactly DEPTH requests, then no more until a pop
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
    fired_q.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    got_fires = fired_q.size();
    check_eq("stall_fires", got_fires, DEPTH);
    check_eq("stall_req_low", {31'b0, s_req}, 32'd0);
    check_eq("stall_head", s_pc, 32'h200);
    d0 = deliveries;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("stall_resume", {31'b0, deliveries > d0 + DEPTH}, 32'd1);

    // Predicted jump at head 0x10 with two requests outstanding
    drain();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("pred_outstanding", pending.size(), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
    check_eq("pred_head_valid", {31'b0, s_valid}, 32'd1);
    check_eq("pred_head_pc", s_pc, 32'h10);
    s_valid = 1'b0;
    for (int i = 0; i < 30 && !s_valid; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("pred_seen", {31'b0, s_valid}, 32'd1);
    check_eq("pred_next_pc", s_pc, 32'h40);

    // EX flush beats a same-cycle predict redirect and same-cycle response
    drain();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("flush_pending", {31'b0, pending.size() > 0}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h103);
    check_eq("flush_had_head", {31'b0, s_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("flush_empty", {31'b0, s_valid}, 32'd0);
    check_eq("flush_addr", s_addr, 32'h100);

    // Address wrap at the top of memory
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8);
    fired_q.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("wrap_count", {31'b0, fired_q.size() >= 3}, 32'd1);
    if (fired_q.size() >= 3) begin
      check_eq("wrap_addr0", fired_q[0], 32'hFFFF_FFF8);
      check_eq("wrap_addr1", fired_q[1], 32'hFFFF_FFFC);
      check_eq("wrap_addr2", fired_q[2], 32'h0000_0000);
    end

    // Random stalls, predictions, flushes and one mid-run reset
    d0 = deliveries;
    for (int i = 0; i < 3000; i++) begin
      logic fl, rdy;
      fl  = ($urandom_range(0, 31) == 0);
      rdy = !fl && ($urandom_range(0, 3) != 0);
      step((i == 1500 || i == 1501), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           rdy, ($urandom_range(0, 7) == 0), $urandom, fl, $urandom);
    end
    check_eq("random_progress", {31'b0, deliveries > d0 + 300}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
